case_convert_stream: RTL and testbench



---
 rtl/case_convert_stream_pkg.sv | 33 +++
 rtl/case_convert_stream_lane.sv | 48 ++++
 rtl/case_convert_stream.sv | 112 +++++++++++
 tb/tb_case_convert_stream.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/case_convert_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : case_pkg
//  Description : Shared mode encoding, ASCII letter bounds and letter-class
//                helpers for the streaming case converter.
//  Revision    : 1.0  initial release
// ============================================================================
package case_pkg;

    // Per-beat conversion mode as carried on the mode port
    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_UPPER  = 2'b01,
        MODE_LOWER  = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    localparam logic [7:0] UC_LO    = 8'h41;
    localparam logic [7:0] UC_HI    = 8'h5A;
    localparam logic [7:0] LC_LO    = 8'h61;
    localparam logic [7:0] LC_HI    = 8'h7A;
    localparam int         CASE_BIT = 5;

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= UC_LO) && (b <= UC_HI);
    endfunction

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= LC_LO) && (b <= LC_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/case_convert_stream_lane.sv
`default_nettype none
// ============================================================================
//  Module      : case_lane
//  Description : Combinational single-byte case converter. Flips the case bit
//                of ASCII letters according to mode; dropped lanes read 0x00.
//  Revision    : 1.0  initial release
// ============================================================================
module case_lane
    import case_pkg::*;
(
    input  logic [7:0] in_byte,
    input  logic [1:0] mode,
    input  logic       keep,
    output logic [7:0] out_byte,
    output logic       changed
);

    logic w_is_up;
    logic w_is_lo;
    logic w_flip;

    assign w_is_up = is_upper(in_byte);
    assign w_is_lo = is_lower(in_byte);

    // Decide whether this byte's case bit flips under the current mode
    always_comb begin
        w_flip = 1'b0;
        case (mode)
            MODE_UPPER:  w_flip = w_is_lo;
            MODE_LOWER:  w_flip = w_is_up;
            MODE_TOGGLE: w_flip = w_is_up | w_is_lo;
            default:     w_flip = 1'b0;
        endcase
    end

    // Build the output byte; lanes without keep are forced to zero
    always_comb begin
        out_byte = 8'h00;
        if (keep) begin
            out_byte           = in_byte;
            out_byte[CASE_BIT] = in_byte[CASE_BIT] ^ w_flip;
        end
    end

    assign changed = keep & w_flip;

endmodule
`default_nettype wire

// File: rtl/case_convert_stream.sv
`default_nettype none
// ============================================================================
//  Module      : case_convert_stream
//  Description : LANES-wide streaming ASCII case converter with valid/ready
//                handshake, one-cycle registered output and a saturating
//                count of changed characters.
//  Revision    : 1.0  initial release
// ============================================================================
module case_convert_stream
    import case_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_keep,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_keep,
    input  logic                 clr_count,
    output logic [CNT_W-1:0]     conv_count
);

    localparam int PC_W  = $clog2(LANES + 1);
    // One spare bit so the sum can exceed the counter maximum before clamping
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] C_CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [8*LANES-1:0] w_conv_data;
    logic [LANES-1:0]   w_changed;
    logic [PC_W-1:0]    w_pop;
    logic               w_xfer;
    logic [CNT_W-1:0]   w_base;
    logic [SUM_W-1:0]   w_sum;
    logic [CNT_W-1:0]   w_count_next;

    logic               r_valid;
    logic [8*LANES-1:0] r_data;
    logic [LANES-1:0]   r_keep;
    logic [CNT_W-1:0]   r_count;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            case_lane u_lane (
                .in_byte  (in_data[8*g +: 8]),
                .mode     (mode),
                .keep     (in_keep[g]),
                .out_byte (w_conv_data[8*g +: 8]),
                .changed  (w_changed[g])
            );
        end
    endgenerate

    // Output slot is free when empty or being drained this cycle
    assign in_ready = !r_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    // Count lanes whose byte was actually modified
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + PC_W'(w_changed[i]);
        end
    end

    // Clear takes priority over the old value, then the beat total is added
    always_comb begin
        w_base       = clr_count ? '0 : r_count;
        w_sum        = SUM_W'(w_base) + SUM_W'(w_pop);
        w_count_next = (w_sum > C_CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    // Output register: load on input transfer, empty when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_conv_data;
            r_keep  <= in_keep;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating changed-character counter with synchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_xfer) begin
            r_count <= w_count_next;
        end else if (clr_count) begin
            r_count <= '0;
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_keep   = r_keep;
    assign conv_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_case_convert_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_case_convert_stream
//  Description : Self-checking bench for case_convert_stream. Two instances
//                (16-bit and 4-bit counters) share one stimulus stream and
//                are compared against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_case_convert_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_keep;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready,  in_ready_s;
    logic        out_valid, out_valid_s;
    logic [31:0] out_data,  out_data_s;
    logic [3:0]  out_keep,  out_keep_s;
    logic [15:0] conv_count;
    logic [3:0]  conv_count_s;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit          exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    int          exp_cnt16;
    int          exp_cnt4;

    always #5 clk = ~clk;

    case_convert_stream #(.LANES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keep(in_keep),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep),
        .clr_count(clr_count), .conv_count(conv_count)
    );

    case_convert_stream #(.LANES(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_keep(in_keep),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_keep(out_keep_s),
        .clr_count(clr_count), .conv_count(conv_count_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ASCII rules expressed as arithmetic on character codes
    function automatic logic [7:0] ref_byte(input logic [7:0] b, input logic [1:0] m);
        bit up = (b >= 8'd65) && (b <= 8'd90);
        bit lo = (b >= 8'd97) && (b <= 8'd122);
        case (m)
            2'd1: if (lo) return b - 8'd32;
            2'd2: if (up) return b + 8'd32;
            2'd3: begin
                if (up) return b + 8'd32;
                if (lo) return b - 8'd32;
            end
            default: ;
        endcase
        return b;
    endfunction

    function automatic int sat_add(input int base, input int inc, input int maxv);
        int s = base + inc;
        return (s > maxv) ? maxv : s;
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_keep  = '0;
        exp_cnt16 = 0;
        exp_cnt4  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"},  out_valid,    exp_valid);
        check({tag, "_data"},   out_data,     exp_data);
        check({tag, "_keep"},   out_keep,     exp_keep);
        check({tag, "_cnt16"},  conv_count,   exp_cnt16);
        check({tag, "_cnt4"},   conv_count_s, exp_cnt4);
        check({tag, "_data_s"}, out_data_s,   exp_data);
    endtask

    // One clock cycle: drive inputs, check in_ready, clock, update model, check
    task automatic step(input string tag, input logic [1:0] m, input logic v,
                        input logic [31:0] d, input logic [3:0] k,
                        input logic ordy, input logic clr);
        bit          rdy;
        logic [31:0] od;
        int          nchg;
        mode = m; in_valid = v; in_data = d; in_keep = k;
        out_ready = ordy; clr_count = clr;
        #1;
        rdy = !exp_valid || ordy;
        check({tag, "_in_ready"}, in_ready, rdy);
        check({tag, "_in_ready_s"}, in_ready_s, rdy);
        od = '0; nchg = 0;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                od[8*i +: 8] = ref_byte(d[8*i +: 8], m);
                if (od[8*i +: 8] != d[8*i +: 8]) nchg++;
            end
        end
        @(posedge clk);
        if (v && rdy) begin
            exp_valid = 1'b1;
            exp_data  = od;
            exp_keep  = k;
            exp_cnt16 = sat_add(clr ? 0 : exp_cnt16, nchg, 65535);
            exp_cnt4  = sat_add(clr ? 0 : exp_cnt4,  nchg, 15);
        end else begin
            if (ordy) exp_valid = 1'b0;
            if (clr) begin
                exp_cnt16 = 0;
                exp_cnt4  = 0;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return 8'(8'h41 + $urandom_range(0, 25));
            1:       return 8'(8'h61 + $urandom_range(0, 25));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; mode = 2'b00; in_valid = 1'b0; in_data = '0;
        in_keep = '0; out_ready = 1'b0; clr_count = 1'b0;
        model_reset();

        // Reset state
        #3;
        check_outputs("reset");
        check("reset_in_ready", in_ready, 1'b1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: upper mode, full keep
        step("up1", 2'b01, 1'b1, 32'h7A41_6140, 4'hF, 1'b1, 1'b0);
        check("up1_const", out_data, 32'h5A41_4140);
        check("up1_cnt_const", conv_count, 16'd2);

        // Directed: toggle mode, lane 3 dropped
        step("tog", 2'b11, 1'b1, 32'h615A_31FF, 4'b0111, 1'b1, 1'b0);
        check("tog_const", out_data, 32'h007A_31FF);
        check("tog_keep_const", out_keep, 4'b0111);
        check("tog_cnt_const", conv_count, 16'd3);

        // Backpressure: load a beat, stall three cycles with a second beat pending
        step("bp_load", 2'b01, 1'b1, 32'h6162_6364, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("bp_hold", 2'b10, 1'b1, 32'h4142_4344, 4'hF, 1'b0, 1'b0);
        check("bp_hold_const", out_data, 32'h4142_4344);
        step("bp_take", 2'b10, 1'b1, 32'h4142_4344, 4'hF, 1'b1, 1'b0);
        check("bp_take_const", out_data, 32'h6162_6364);
        for (int i = 0; i < 4; i++)
            step("b2b", 2'($urandom_range(0, 3)), 1'b1,
                 {rand_byte(), rand_byte(), rand_byte(), rand_byte()}, 4'hF, 1'b1, 1'b0);

        // Pass and lower modes over the uppercase alphabet
        for (int md = 0; md < 3; md += 2) begin
            for (int b = 0; b < 26; b += 4) begin
                w = '0;
                for (int l = 0; l < 4; l++) w[8*l +: 8] = 8'(8'h41 + b + l);
                step(md == 0 ? "alpha_pass" : "alpha_lower", 2'(md), 1'b1, w,
                     (b == 24) ? 4'b0011 : 4'hF, 1'b1, 1'b0);
            end
        end

        // High-bit look-alikes never change
        for (int md = 0; md < 4; md++)
            step("hibit", 2'(md), 1'b1, 32'hC1E1_C1E1, 4'hF, 1'b1, 1'b0);

        // Saturation of the 4-bit counter, then clear with a concurrent beat
        step("sat_clr", 2'b00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            step("sat", 2'b01, 1'b1, 32'h6162_7A78, 4'hF, 1'b1, 1'b0);
        check("sat_cnt4_const", conv_count_s, 4'd15);
        check("sat_cnt16_const", conv_count, 16'd20);
        step("clr_beat", 2'b01, 1'b1, 32'h6162_6364, 4'hF, 1'b1, 1'b1);
        check("clr_beat_const", conv_count_s, 4'd4);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 {rand_byte(), rand_byte(), rand_byte(), rand_byte()},
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));

        // Asynchronous reset while a beat is held under backpressure
        step("pre_rst_load", 2'b01, 1'b1, 32'h6161_6161, 4'hF, 1'b1, 1'b0);
        step("pre_rst_hold", 2'b01, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("async_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step("post_rst_idle", 2'b01, 1'b0, 32'h6161_6161, 4'hF, 1'b1, 1'b0);
        step("post_rst_beat", 2'b01, 1'b1, 32'h6161_4141, 4'hF, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
